// File: rtl/md_unit.sv
// md_unit -- multiply/divide unit for the EX stage.
//
// Holds the architectural HI/LO registers. MULT/MULTU (and DIV/DIVU when
// the divider is built) compute the full result in the start cycle, park it
// in temporaries, and commit it to HI/LO after a fixed busy latency so the
// pipeline sees realistic multi-cycle timing. MTHI/MTLO write HI/LO directly
// and MFHI/MFLO read the committed values combinationally.
//
// Build option: define MD_UNIT_DIV_EN to include the divider. Without it,
// DIV/DIVU decode as NONE.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous, active-high reset
//   en     in   EX-stage instruction valid (0 forces mdOp to NONE)
//   mdOp   in   [3:0] operation code
//   A      in   [31:0] rs operand
//   B      in   [31:0] rt operand
//   start  out  a multiply/divide is being launched this cycle
//   busy   out  a multiply/divide is in flight (registered)
//   out    out  [31:0] HI for MFHI, LO for MFLO, else 0

module md_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [3:0]  mdOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        start,
  output logic        busy,
  output logic [31:0] out
);

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam logic [3:0] MUL_LATENCY = 4'd5;
  localparam logic [3:0] DIV_LATENCY = 4'd10;

`ifdef MD_UNIT_DIV_EN
  localparam logic DIV_EN = 1'b1;
`else
  localparam logic DIV_EN = 1'b0;
`endif

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] tmp_hi_q, tmp_hi_d;
  logic [31:0] tmp_lo_q, tmp_lo_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;

  logic [3:0]  op_eff;
  logic        is_mul, is_div, is_mfhi, is_mflo, is_mthi, is_mtlo;
  logic [63:0] mul_res;
  logic [63:0] div_res;

  // Decode; an invalid EX slot and reserved codes both behave as NONE.
  always_comb begin
    op_eff  = en ? mdOp : OP_NONE;
    is_mul  = 1'b0;
    is_div  = 1'b0;
    is_mfhi = 1'b0;
    is_mflo = 1'b0;
    is_mthi = 1'b0;
    is_mtlo = 1'b0;
    case (op_eff)
      OP_MULT, OP_MULTU: is_mul  = 1'b1;
      OP_DIV, OP_DIVU:   is_div  = DIV_EN;
      OP_MFHI:           is_mfhi = 1'b1;
      OP_MFLO:           is_mflo = 1'b1;
      OP_MTHI:           is_mthi = 1'b1;
      OP_MTLO:           is_mtlo = 1'b1;
      default:           ;
    endcase
  end

  // Full 64-bit product, sign- or zero-extended operands.
  always_comb begin
    if (op_eff == OP_MULT) begin
      mul_res = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    end else begin
      mul_res = {32'd0, A} * {32'd0, B};
    end
  end

`ifdef MD_UNIT_DIV_EN
  logic [31:0] div_q, div_r;

  // Divide by zero re-issues the committed HI/LO so the later commit is a
  // no-op. The most-negative / -1 case is pinned explicitly because the
  // true quotient does not fit in 32 bits.
  always_comb begin
    div_q = lo_q;
    div_r = hi_q;
    if (B == 32'd0) begin
      div_q = lo_q;
      div_r = hi_q;
    end else if (op_eff == OP_DIV) begin
      if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
        div_q = 32'h8000_0000;
        div_r = 32'd0;
      end else begin
        div_q = $signed(A) / $signed(B);
        div_r = $signed(A) % $signed(B);
      end
    end else begin
      div_q = A / B;
      div_r = A % B;
    end
  end

  assign div_res = {div_r, div_q};
`else
  assign div_res = 64'd0;
`endif

  assign start = (is_mul | is_div) & ~busy_q;
  assign busy  = busy_q;

  always_comb begin
    out = 32'd0;
    if (is_mfhi) begin
      out = hi_q;
    end else if (is_mflo) begin
      out = lo_q;
    end
  end

  // Start, countdown/commit and MT writes are mutually exclusive because
  // start and MT both require busy to be low.
  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    tmp_hi_d = tmp_hi_q;
    tmp_lo_d = tmp_lo_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start) begin
      {tmp_hi_d, tmp_lo_d} = is_div ? div_res : mul_res;
      cnt_d  = is_div ? DIV_LATENCY : MUL_LATENCY;
      busy_d = 1'b1;
    end else if (busy_q) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        hi_d   = tmp_hi_q;
        lo_d   = tmp_lo_q;
        busy_d = 1'b0;
      end
    end else if (is_mthi) begin
      hi_d = A;
    end else if (is_mtlo) begin
      lo_d = A;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      tmp_hi_q <= 32'd0;
      tmp_lo_q <= 32'd0;
      cnt_q    <= 4'd0;
      busy_q   <= 1'b0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      tmp_hi_q <= tmp_hi_d;
      tmp_lo_q <= tmp_lo_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit -- scoreboard bench for md_unit.
//
// Stimulus computes the expected start/busy/out for each cycle from an
// arithmetic model of HI/LO and queues it; a monitor on the falling edge
// pops each entry and compares it with the DUT. Directed sequences cover
// the worked examples, then randomized instructions (including resets and
// operations issued while busy) follow.

module tb_md_unit;

`ifdef MD_UNIT_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        en;
  logic [3:0]  md_op;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        start;
  logic        busy;
  logic [31:0] out;

  md_unit dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .mdOp  (md_op),
    .A     (a_in),
    .B     (b_in),
    .start (start),
    .busy  (busy),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] cycle;
    logic        start;
    logic        busy;
    logic [31:0] out;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cycle_no = 0;

  // Architectural model: committed HI/LO, the pending result and the
  // number of busy cycles still to run.
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [63:0] m_pend;
  int          m_left;

  // Result of an operation computed with 64-bit integer arithmetic.
  function automatic logic [63:0] refResult(input int op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] hi,
                                            input logic [31:0] lo);
    longint          sa, sb, q, r, p;
    longint unsigned ua, ub, uq, ur;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      1: begin
        p = sa * sb;
        return p;
      end
      2: return ua * ub;
      3: begin
        if (b == 32'd0) return {hi, lo};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      4: begin
        if (b == 32'd0) return {hi, lo};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      default: return {hi, lo};
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] cyc,
                             input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s cycle %0d: got 0x%08h expected 0x%08h", name, cyc, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, queue the expected outputs, advance the model
  // across the coming clock edge, then wait for that edge.
  task automatic applyStimulus(input logic rst, input logic e, input logic [3:0] op,
                               input logic [31:0] a, input logic [31:0] b);
    int   eop;
    logic m_busy;
    logic launch;
    exp_t x;
    reset = rst;
    en    = e;
    md_op = op;
    a_in  = a;
    b_in  = b;
    eop    = e ? int'(op) : 0;
    m_busy = (m_left > 0);
    launch = !m_busy && (eop == 1 || eop == 2 || (DIV_EN && (eop == 3 || eop == 4)));
    x.cycle = cycle_no;
    x.start = launch;
    x.busy  = m_busy;
    x.out   = (eop == 5) ? m_hi : (eop == 6) ? m_lo : 32'd0;
    exp_q.push_back(x);
    if (rst) begin
      m_hi = 0; m_lo = 0; m_pend = 0; m_left = 0;
    end else if (launch) begin
      m_pend = refResult(eop, a, b, m_hi, m_lo);
      m_left = (eop >= 3) ? 10 : 5;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) {m_hi, m_lo} = m_pend;
    end else if (eop == 7) begin
      m_hi = a;
    end else if (eop == 8) begin
      m_lo = a;
    end
    @(posedge clk);
    #1;
    cycle_no++;
  endtask

  // Idle cycles carry random opcodes with en low, which must do nothing.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 4'($urandom_range(0, 15)), $urandom(), $urandom());
    end
  endtask

  task automatic op(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
    applyStimulus(1'b0, 1'b1, code, a, b);
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  // Monitor: compare every queued expectation on the falling edge.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        checkOutput("start", x.cycle, {31'd0, start}, {31'd0, x.start});
        checkOutput("busy",  x.cycle, {31'd0, busy},  {31'd0, x.busy});
        checkOutput("out",   x.cycle, out, x.out);
      end
    end
  end

  initial begin
    int r;
    logic [3:0] rop;
    m_hi = 0; m_lo = 0; m_pend = 0; m_left = 0;
    reset = 1'b1; en = 1'b0; md_op = 4'd0; a_in = 32'd0; b_in = 32'd0;
    @(posedge clk);
    #1;
    // Reset state and the combinational start under reset.
    applyStimulus(1'b1, 1'b1, 4'd1, 32'd7, 32'd9);
    op(4'd5, 32'd0, 32'd0);
    op(4'd6, 32'd0, 32'd0);

    // Signed multiply -2 * 3, read LO right after busy falls.
    op(4'd1, 32'hFFFF_FFFE, 32'd3);
    idle(5);
    op(4'd6, 32'd0, 32'd0);
    op(4'd5, 32'd0, 32'd0);

    // Unsigned multiply; MFHI during busy returns the old HI.
    applyStimulus(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
    op(4'd2, 32'hFFFF_FFFF, 32'd2);
    op(4'd5, 32'd0, 32'd0);
    idle(4);
    op(4'd5, 32'd0, 32'd0);
    op(4'd6, 32'd0, 32'd0);

    // Signed divide, divide by zero, overflow case, unsigned divide.
    op(4'd3, 32'hFFFF_FFF9, 32'd2);
    op(4'd6, 32'd0, 32'd0);
    idle(9);
    op(4'd6, 32'd0, 32'd0);
    op(4'd5, 32'd0, 32'd0);
    op(4'd3, 32'd123, 32'd0);
    idle(10);
    op(4'd6, 32'd0, 32'd0);
    op(4'd5, 32'd0, 32'd0);
    op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    idle(10);
    op(4'd6, 32'd0, 32'd0);
    op(4'd5, 32'd0, 32'd0);
    op(4'd4, 32'hFFFF_FFF9, 32'd2);
    idle(10);
    op(4'd6, 32'd0, 32'd0);
    op(4'd5, 32'd0, 32'd0);

    // MTHI then MFHI; MTLO during a multiply is ignored.
    op(4'd7, 32'h1234_5678, 32'd0);
    op(4'd5, 32'd0, 32'd0);
    op(4'd1, 32'd3, 32'd4);
    op(4'd8, 32'd5, 32'd0);
    op(4'd2, 32'd9, 32'd9);
    idle(3);
    op(4'd6, 32'd0, 32'd0);
    op(4'd5, 32'd0, 32'd0);

    // Reset in the middle of a DIVU discards the pending result.
    op(4'd4, 32'd100, 32'd7);
    idle(3);
    applyStimulus(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
    for (int i = 0; i < 12; i++) op(4'd6, 32'd0, 32'd0);
    op(4'd5, 32'd0, 32'd0);

    // Reserved opcodes behave as NONE.
    for (int i = 9; i < 16; i++) op(4'(i), 32'hDEAD_BEEF, 32'd3);
    op(4'd5, 32'd0, 32'd0);

    // Randomized instruction stream.
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 19);
      if (r < 9)       rop = 4'(r);
      else if (r < 15) rop = 4'($urandom_range(5, 6));
      else             rop = 4'($urandom_range(0, 15));
      applyStimulus(($urandom_range(0, 80) == 0), ($urandom_range(0, 9) != 0),
                    rop, pickOperand(), pickOperand());
    end
    applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("[TB] FAIL drain: got %0d entries pending expected 0", exp_q.size());
    end
    @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
